// File: rtl/rx_vref_cal_if.sv
// Handshake/data bundle between a lane's vref calibration sequencer and its controller/tile.
// Optional trace outputs appear when RX_VREF_CAL_TRACE_EN is defined.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif
`ifndef RDAC_SEL_BITS
`define RDAC_SEL_BITS 4
`endif

interface rx_vref_cal_if #(
  parameter int DATA_W = 2**`SERDES_STAGES,
  parameter int SEL_W  = `RDAC_SEL_BITS,
  parameter int CNT_W  = 9
);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] dout_in;
  logic [SEL_W-1:0]  vref_sel;
  logic              busy;
  logic              done;
  logic              fail;
  logic [SEL_W-1:0]  result;
`ifdef RX_VREF_CAL_TRACE_EN
  logic              trace_valid;
  logic [SEL_W-1:0]  trace_code;
  logic [CNT_W-1:0]  trace_ones;

  modport master (output start, abort, dout_in,
                  input  vref_sel, busy, done, fail, result, trace_valid, trace_code, trace_ones);
  modport slave  (input  start, abort, dout_in,
                  output vref_sel, busy, done, fail, result, trace_valid, trace_code, trace_ones);
`else
  modport master (output start, abort, dout_in,
                  input  vref_sel, busy, done, fail, result);
  modport slave  (input  start, abort, dout_in,
                  output vref_sel, busy, done, fail, result);
`endif
endinterface

// File: rtl/rx_vref_cal_ctrl.sv
// Vref calibration sequencer: sweeps the rdac code upward and locks on the first code whose
// ones density is <= 50%. Optional EVAL trace port enabled by RX_VREF_CAL_TRACE_EN.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif
`ifndef RDAC_SEL_BITS
`define RDAC_SEL_BITS 4
`endif

module rx_vref_cal_ctrl #(
  parameter int DATA_W        = 2**`SERDES_STAGES,
  parameter int SEL_W         = `RDAC_SEL_BITS,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_WORDS  = 64,
  parameter int VREF_DEFAULT  = 0
) (
  input logic          clk,
  input logic          rst,
  rx_vref_cal_if.slave bus
);
  localparam int CNT_W = $clog2(SAMPLE_WORDS*DATA_W+1);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'((SAMPLE_WORDS*DATA_W)/2);
  localparam int TMAX = (SETTLE_CYCLES > SAMPLE_WORDS) ? SETTLE_CYCLES : SAMPLE_WORDS;
  localparam int TW = $clog2(TMAX+1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES-1);
  localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_WORDS-1);
  localparam logic [SEL_W-1:0] MAX_CODE = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] DEF_CODE = SEL_W'(VREF_DEFAULT);

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, DONE} state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    cnt;
  logic [CNT_W-1:0] ones;
  logic [SEL_W-1:0] code, result_q;
  logic             fail_q;

  function automatic logic [CNT_W-1:0] popcnt(input logic [DATA_W-1:0] w);
    popcnt = '0;
    for (int i = 0; i < DATA_W; i++) popcnt = popcnt + CNT_W'(w[i]);
  endfunction

  wire [CNT_W-1:0] ones_acc = ones + popcnt(bus.dout_in);
  wire             pass     = (ones <= THRESH);
  wire             last_cnt = (state == SETTLE) ? (cnt == SETTLE_LAST) : (cnt == SAMPLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start && !bus.abort) state_nxt = SETTLE;
      SETTLE: if (bus.abort) state_nxt = IDLE;
              else if (last_cnt) state_nxt = SAMPLE;
      SAMPLE: if (bus.abort) state_nxt = IDLE;
              else if (last_cnt) state_nxt = EVAL;
      EVAL:   if (bus.abort) state_nxt = IDLE;
              else if (pass || code == MAX_CODE) state_nxt = DONE;
              else state_nxt = SETTLE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // code doubles as the driven vref_sel; on lock it already equals result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code     <= DEF_CODE;
      result_q <= DEF_CODE;
      fail_q   <= 1'b0;
      ones     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          code <= result_q;
          cnt  <= '0;
          if (bus.start && !bus.abort) begin
            code   <= '0;
            fail_q <= 1'b0;
            ones   <= '0;
          end
        end
        SETTLE, SAMPLE: begin
          if (bus.abort) begin
            code <= result_q;
            cnt  <= '0;
          end else begin
            cnt <= last_cnt ? '0 : cnt + 1'b1;
            if (state == SAMPLE) ones <= ones_acc;
          end
        end
        EVAL: begin
          cnt <= '0;
          if (bus.abort) begin
            code <= result_q;
          end else if (pass) begin
            result_q <= code;
          end else if (code == MAX_CODE) begin
            fail_q   <= 1'b1;
            result_q <= code;
          end else begin
            code <= code + 1'b1;
            ones <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.vref_sel = code;
  assign bus.result   = result_q;
  assign bus.fail     = fail_q;
  assign bus.busy     = (state == SETTLE) || (state == SAMPLE) || (state == EVAL);
  assign bus.done     = (state == DONE);

`ifdef RX_VREF_CAL_TRACE_EN
  // Registered on SAMPLE->EVAL so the pulse lines up with the EVAL cycle itself
  logic             trace_valid_q;
  logic [SEL_W-1:0] trace_code_q;
  logic [CNT_W-1:0] trace_ones_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_code_q  <= '0;
      trace_ones_q  <= '0;
    end else begin
      trace_valid_q <= (state == SAMPLE) && (state_nxt == EVAL);
      if ((state == SAMPLE) && (state_nxt == EVAL)) begin
        trace_code_q <= code;
        trace_ones_q <= ones_acc;
      end
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_code  = trace_code_q;
  assign bus.trace_ones  = trace_ones_q;
`endif
endmodule

// File: tb/tb_rx_vref_cal_ctrl.sv
// Self-checking bench for rx_vref_cal_ctrl: vector table of tile models plus hand sequences
// for abort, reset and ignored-start cases; done pulses are checked against a scoreboard.
module tb_rx_vref_cal_ctrl;
  localparam int DW = 4, SW = 4, ST = 4, SWD = 8;
  localparam int CW = $clog2(SWD*DW+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_vref_cal_if #(.DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) bus();

  rx_vref_cal_ctrl #(.DATA_W(DW), .SEL_W(SW), .SETTLE_CYCLES(ST), .SAMPLE_WORDS(SWD),
                     .VREF_DEFAULT(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int mode; logic [3:0] arg; logic [3:0] res; logic fl; int cyc; } vec_t;
  typedef struct { logic [3:0] res; logic fl; int cyc; } exp_t;

  exp_t       sb[$];
  vec_t       vt[9];
  int         nchk = 0, nfail = 0, cyc = 0, ndone = 0;
  int         mode = 1;
  logic [3:0] arg = 4'h0;

  // Tile model: 0 = all ones below trip code arg, 1 = constant word arg, 2 = 0111 below arg else 0011
  always_comb begin
    case (mode)
      0:       bus.dout_in = (bus.vref_sel < arg) ? 4'hF : 4'h0;
      1:       bus.dout_in = arg;
      default: bus.dout_in = (bus.vref_sel < arg) ? 4'b0111 : 4'b0011;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] r, input logic f, input int c);
    exp_t e;
    e.res = r; e.fl = f; e.cyc = c;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      ndone++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("result", bus.result, e.res);
        chk("fail", bus.fail, e.fl);
        chk("vref_at_done", bus.vref_sel, e.res);
        chk("busy_at_done", bus.busy, 0);
      end
    end
  end

`ifdef RX_VREF_CAL_TRACE_EN
  logic [3:0] tcodes[$];
  always @(negedge clk) if (bus.trace_valid === 1'b1) tcodes.push_back(bus.trace_code);
`endif

  // start is high during cycle 0 and sampled by the edge that opens cycle 1
  task automatic run(input int md, input logic [3:0] a, input bit push, input exp_t e,
                     input bit extra_starts, input int abort_at);
    mode = md; arg = a;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b1; cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); cyc++; #1;
      bus.start = extra_starts && (cyc == 20 || cyc == 40);
      bus.abort = (cyc == abort_at);
      if (cyc == 1) begin
        chk("busy_after_start", bus.busy, 1);
        chk("fail_cleared", bus.fail, 0);
        chk("vref_first_code", bus.vref_sel, 0);
      end
      if (abort_at > 0 && cyc == abort_at + 1) begin
        chk("busy_after_abort", bus.busy, 0);
        chk("vref_after_abort", bus.vref_sel, e.res);
        chk("result_after_abort", bus.result, e.res);
        break;
      end
      if (push && sb.size() == 0) break;
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    if (push && sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
    repeat (2) @(posedge clk); #1;
    chk("idle_vref", bus.vref_sel, e.res);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int d0;
    vt[0] = '{0, 4'd9,     4'd9,  1'b0, 131};
    vt[1] = '{1, 4'b0011,  4'd0,  1'b0, 14};
    vt[2] = '{1, 4'hF,     4'd15, 1'b1, 209};
    vt[3] = '{0, 4'd1,     4'd1,  1'b0, 27};
    vt[4] = '{0, 4'd15,    4'd15, 1'b0, 209};
    vt[5] = '{1, 4'b0111,  4'd15, 1'b1, 209};
    vt[6] = '{2, 4'd5,     4'd5,  1'b0, 79};
    vt[7] = '{0, 4'd0,     4'd0,  1'b0, 14};
    vt[8] = '{1, 4'b0001,  4'd0,  1'b0, 14};

    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_vref", bus.vref_sel, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fail", bus.fail, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run(vt[i].mode, vt[i].arg, 1'b1, mk(vt[i].res, vt[i].fl, vt[i].cyc), 1'b0, -1);

    // Abort mid-sweep keeps the previous lock and emits no done
    run(0, 4'd9, 1'b1, mk(4'd9, 1'b0, 131), 1'b0, -1);
    d0 = ndone;
    run(0, 4'd9, 1'b0, mk(4'd9, 1'b0, 0), 1'b0, 50);
    repeat (250) @(posedge clk); #1;
    chk("no_done_after_abort", ndone, d0);
    chk("vref_held_after_abort", bus.vref_sel, 9);
    chk("fail_after_abort", bus.fail, 0);

    // start and abort together in IDLE: abort wins
    @(posedge clk); #1; bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("start_abort_idle", bus.busy, 0);
    chk("start_abort_no_done", ndone, d0);

    // Reset during SAMPLE returns everything to defaults
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (7) @(posedge clk); #1;
    chk("busy_before_rst", bus.busy, 1);
    rst = 1'b1; #1;
    chk("rst_mid_vref", bus.vref_sel, 0);
    chk("rst_mid_result", bus.result, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(posedge clk); #1; rst = 1'b0;
    run(0, 4'd9, 1'b1, mk(4'd9, 1'b0, 131), 1'b0, -1);

    // Extra start pulses while busy do not disturb timing
`ifdef RX_VREF_CAL_TRACE_EN
    tcodes.delete();
`endif
    run(0, 4'd9, 1'b1, mk(4'd9, 1'b0, 131), 1'b1, -1);
`ifdef RX_VREF_CAL_TRACE_EN
    chk("trace_count", tcodes.size(), 10);
    for (int i = 0; i < tcodes.size(); i++) chk("trace_code", tcodes[i], i);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
